// File: rtl/uart_pkg.sv
// Shared UART constants: payload width, bit timing at 100 MHz / 9600 baud,
// default receive-FIFO depth, and a saturating-increment helper.
package uart_pkg;

   localparam int UART_DW         = 8;
   localparam int CLKS_PER_BIT    = 10416;
   localparam int HALF_BIT        = 5208;
   localparam int UART_RX_FIFO_AW = 4;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage for the receive FIFO: registered write port and
// asynchronous read port. Contents are never reset.
module uart_fifo_ram #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [DW-1:0] i_wr_data,
   input  logic [AW-1:0] i_rd_addr,
   output logic [DW-1:0] o_rd_data
);

   logic [DW-1:0] r_mem [2**AW];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with first-word-fall-through valid/ready output and a sticky
// overrun flag. Define UART_RX_FIFO_STATS_EN to add the dropped-byte counter port.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DW       = UART_DW,
   parameter int AW       = UART_RX_FIFO_AW,
   parameter int AF_LEVEL = 12
) (
   input  logic          clk,
   input  logic          i_reset,
   input  logic          i_wr_valid,
   input  logic [DW-1:0] i_wr_data,
   output logic          o_rd_valid,
   output logic [DW-1:0] o_rd_data,
   input  logic          i_rd_ready,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_almost_full,
   output logic          o_overrun,
   input  logic          i_clr_overrun
`ifdef UART_RX_FIFO_STATS_EN
   ,output logic [7:0]   o_overrun_cnt
`endif
);

   localparam logic [AW:0] DEPTH     = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] AF_THRESH = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        r_overrun;
   logic [AW:0] w_count;
   logic        w_full;
   logic        w_rd_valid;
   logic        w_pop;
   logic        w_push;
   logic        w_drop;

   // Pointers carry one extra bit so a full FIFO and an empty one differ.
   assign w_count    = r_wr_ptr - r_rd_ptr;
   assign w_full     = (w_count == DEPTH);
   assign w_rd_valid = (w_count != '0);
   assign w_pop      = w_rd_valid & i_rd_ready;
   assign w_push     = i_wr_valid & (~w_full | w_pop);
   assign w_drop     = i_wr_valid & w_full & ~w_pop;

   uart_fifo_ram #(.DW(DW), .AW(AW)) u_ram (
      .clk       (clk),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr[AW-1:0]),
      .i_wr_data (i_wr_data),
      .i_rd_addr (r_rd_ptr[AW-1:0]),
      .o_rd_data (o_rd_data)
   );

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (i_clr_overrun) begin
         r_overrun <= 1'b0;
      end
   end

`ifdef UART_RX_FIFO_STATS_EN
   logic [7:0] r_overrun_cnt;

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         r_overrun_cnt <= 8'd0;
      end else if (w_drop) begin
         r_overrun_cnt <= i_clr_overrun ? 8'd1 : sat_inc8(r_overrun_cnt);
      end else if (i_clr_overrun) begin
         r_overrun_cnt <= 8'd0;
      end
   end

   assign o_overrun_cnt = r_overrun_cnt;
`endif

   assign o_rd_valid    = w_rd_valid;
   assign o_count       = w_count;
   assign o_full        = w_full;
   assign o_almost_full = (w_count >= AF_THRESH);
   assign o_overrun     = r_overrun;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the `uart` receiver in the board top. It absorbs the one-cycle byte strobes the receiver produces at 9600 baud (10416 clocks/bit at 100 MHz). It presents the bytes to the consumer (command parser or TX loopback) over a valid/ready handshake. Overruns are flagged instead of silently dropped.

## Interface
Parameters:
- `DW`, 8, data width in bits (receiver payload width).
- `AW`, 4, address width; depth = 2**AW entries.
- `AF_LEVEL`, 12, occupancy at or above which `o_almost_full` asserts; legal range 1..2**AW.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_wr_valid`  in  1  one-cycle strobe from the receiver: byte available.
- `i_wr_data`  in  DW  received byte, sampled when `i_wr_valid`=1.
- `o_rd_valid`  out  1  head entry present on `o_rd_data`.
- `o_rd_data`  out  DW  head entry (first-word-fall-through).
- `i_rd_ready`  in  1  consumer accepts head entry.
- `o_count`  out  AW+1  current occupancy, 0..2**AW.
- `o_full`  out  1  occupancy = 2**AW.
- `o_almost_full`  out  1  occupancy ≥ `AF_LEVEL`.
- `o_overrun`  out  1  sticky: a strobe arrived while the FIFO was full and had no pop.
- `i_clr_overrun`  in  1  synchronous clear of `o_overrun` (and the counter, if compiled in).
- `o_overrun_cnt`  out  8  saturating count of dropped bytes; present only with `UART_RX_FIFO_STATS_EN`.

## Operation
- Storage: 2**AW × DW array. Read and write pointers are AW+1 bits wide and wrap modulo 2**(AW+1). Occupancy = wr_ptr − rd_ptr (modulo). The MSB distinguishes full from empty.
- Push: `i_wr_valid` & (!`o_full` | pop). The byte is written at `wr_ptr[AW-1:0]` and wr_ptr increments.
- Pop: `o_rd_valid` & `i_rd_ready`. rd_ptr increments.
- Drop: `i_wr_valid` & `o_full` & !pop. Nothing is stored, `o_overrun` is set, and the counter increments, saturating at 255.
- Simultaneous push and pop: allowed when full or non-empty. Occupancy is unchanged. When full, the new byte is stored and none is dropped.
- Push into empty: no pop is possible in the same cycle, because `o_rd_valid` is still 0.
- `i_clr_overrun` together with a drop in the same cycle: the set wins. The flag stays 1 and the counter becomes 1.
- `o_rd_data` = mem[rd_ptr[AW-1:0]]. It is a combinational read of registered storage and is stable while `o_rd_valid` is high and no pop occurs.
- `o_rd_valid` = (occupancy ≠ 0). `o_full`, `o_almost_full` and `o_count` are decoded from the registered pointers.
- Reset, at any time and including mid-transfer:
  - pointers go to 0;
  - `o_count`=0, `o_rd_valid`=0, `o_full`=0, `o_almost_full`=0, `o_overrun`=0, `o_overrun_cnt`=0.
  - Array contents are undefined and not reset.

## Timing
- Push at edge N: `o_rd_valid`=1 and `o_count` updated from cycle N+1.
- Pop at edge N: the next entry appears on `o_rd_data` in cycle N+1, or `o_rd_valid` drops if the FIFO becomes empty.
- Sustained throughput: one push and one pop per cycle. The receiver rate (≤1 byte per 104 k cycles) never stresses it.
- `o_overrun` is set at the edge of the drop cycle and visible in the following cycle.
- Reset deassertion: the first push is accepted on the first edge after `i_reset` falls.

## Configuration
- `UART_RX_FIFO_STATS_EN` defined: `o_overrun_cnt` port and its 8-bit saturating counter are present, cleared by reset or `i_clr_overrun`.
- Not defined: port and counter are absent. `o_overrun` is still always present.

## Structure
- Shared package `uart_pkg`:
  - `UART_DW`=8;
  - `CLKS_PER_BIT`=10416 and `HALF_BIT`=5208;
  - default `UART_RX_FIFO_AW`=4.
- One natural sub-module: `uart_fifo_ram`, a simple dual-port array with a registered write and an asynchronous read. The FIFO top holds pointers, flags and counters.

## Test plan
- Reset, then write 0x41, 0x42, 0x43 on separate strobes with `i_rd_ready`=0:
  - `o_count`=3 and `o_rd_data`=0x41;
  - then raise `i_rd_ready` for 3 cycles: the consumer reads 0x41, 0x42, 0x43 in order, after which `o_rd_valid`=0.
- Fill 16 entries (0x00..0x0F):
  - `o_almost_full` rises after the 12th push and `o_full`=1 after the 16th;
  - a 17th strobe (0xAA) sets `o_overrun` and `o_overrun_cnt`=1;
  - the head is still 0x00.
- FIFO full, then strobe 0x55 with `i_rd_ready`=1 in the same cycle: 0x00 is popped, 0x55 is stored at the tail, `o_overrun` stays 0 and `o_count` stays 16.
- Pointer wrap: push and pop 40 bytes 0x00..0x27 with occupancy kept at 1–3. All bytes are read back in order across the wrap, and `o_count` never exceeds 3.
- Overrun clear:
  - drop 300 bytes while full: `o_overrun_cnt`=255, saturated;
  - assert `i_clr_overrun` alone: flag=0 and count=0;
  - `i_clr_overrun` coincident with a drop: flag=1 and count=1.
- Assert `i_reset` with 5 entries held and a strobe in flight:
  - outputs are immediately 0 (asynchronous);
  - after release, push 0x7E: it is the head with `o_count`=1.
